// File: rtl/serial_word_capture.sv
// Serial word capture: deserializes an LSB-first bit stream into 16-bit words
// and stores each frame of NUM_WORDS words into a 16-entry capture memory.
module serial_word_capture #(
    parameter int WORD_W    = 16,
    parameter int NUM_WORDS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic [3:0]        rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic [3:0]        word_idx,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

    state_t            state_q, state_d;
    logic [3:0]        bitCnt_q, bitCnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] assembled;
    logic [3:0]        wordIdx_q, wordIdx_d;
    logic [WORD_W-1:0] wordOut_q, wordOut_d;
    logic              wordValid_q, wordValid_d;
    logic              overrun_q, overrun_d;
    logic              memWe;
    logic [WORD_W-1:0] mem_q [16];

    // assembled is the current word including this cycle's bit, so the
    // completing bit lands in memory on the same edge it is received.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        wordIdx_d   = wordIdx_q;
        wordOut_d   = wordOut_q;
        wordValid_d = 1'b0;
        overrun_d   = overrun_q;
        memWe       = 1'b0;
        assembled   = shift_q;
        assembled[bitCnt_q] = bit_in;

        if (abort) begin
            state_d   = IDLE;
            bitCnt_d  = '0;
            shift_d   = '0;
            wordIdx_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d   = CAPTURE;
                        bitCnt_d  = '0;
                        shift_d   = '0;
                        wordIdx_d = '0;
                        overrun_d = 1'b0;
                    end else if (bit_valid && state_q == DONE) begin
                        overrun_d = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (bit_valid) begin
                        shift_d  = assembled;
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd15) begin
                            memWe       = 1'b1;
                            wordOut_d   = assembled;
                            wordValid_d = 1'b1;
                            bitCnt_d    = '0;
                            shift_d     = '0;
                            if (wordIdx_q == LAST_IDX) begin
                                wordIdx_d = '0;
                                state_d   = DONE;
                            end else begin
                                wordIdx_d = wordIdx_q + 4'd1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            wordIdx_q   <= '0;
            wordOut_q   <= '0;
            wordValid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            wordIdx_q   <= wordIdx_d;
            wordOut_q   <= wordOut_d;
            wordValid_q <= wordValid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Entries 10-15 are never addressed by the word counter and stay zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
        end else if (memWe) begin
            mem_q[wordIdx_q] <= assembled;
        end
    end

    assign rd_data    = mem_q[rd_addr];
    assign word_out   = wordOut_q;
    assign word_valid = wordValid_q;
    assign word_idx   = wordIdx_q;
    assign busy       = (state_q == CAPTURE);
    assign done       = (state_q == DONE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_word_capture.sv
// Scoreboard bench for serial_word_capture: stimulus pushes expected words,
// a negedge monitor pops and compares on every word_valid pulse.
module tb_serial_word_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        bit_in;
    logic        bit_valid;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] word_out;
    logic        word_valid;
    logic [3:0]  word_idx;
    logic        busy;
    logic        done;
    logic        overrun;

    typedef struct {
        logic [15:0] word;
        logic [3:0]  idxAfter;
        logic        doneAfter;
    } expT;

    expT         expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lastCyc = -1;
    int          expGap = 0;
    int          pulses = 0;

    logic [15:0] frameA [10] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010,
                                 16'h0020, 16'h0000, 16'h0000, 16'h0000, 16'h0400};
    logic [15:0] frameF [10] = '{default: 16'hFFFF};

    serial_word_capture #(.WORD_W(16), .NUM_WORDS(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .bit_in(bit_in), .bit_valid(bit_valid), .rd_addr(rd_addr),
        .rd_data(rd_data), .word_out(word_out), .word_valid(word_valid),
        .word_idx(word_idx), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every word_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        expT e;
        if (rst_n === 1'b1 && word_valid === 1'b1) begin
            pulses++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_word_valid", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("word_out", 32'(word_out), 32'(e.word));
                checkOutput("word_idx_after", 32'(word_idx), 32'(e.idxAfter));
                checkOutput("done_after", 32'(done), 32'(e.doneAfter));
            end
            if (expGap != 0 && lastCyc >= 0)
                checkOutput("wv_spacing", 32'(cyc - lastCyc), 32'(expGap));
            lastCyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkMem(input logic [3:0] addr, input logic [15:0] exp);
        rd_addr = addr;
        #1;
        checkOutput($sformatf("mem[%0d]", addr), 32'(rd_data), 32'(exp));
    endtask

    task automatic applyStimulus(input logic [15:0] w, input bit push,
                                 input logic [3:0] idxAfter, input logic doneAfter,
                                 input bit gap);
        expT e;
        if (push) begin
            e.word = w; e.idxAfter = idxAfter; e.doneAfter = doneAfter;
            expQ.push_back(e);
        end
        for (int b = 0; b < 16; b++) begin
            bit_in = w[b];
            bit_valid = 1'b1;
            tick();
            bit_valid = 1'b0;
            bit_in = 1'b0;
            if (gap) tick();
        end
    endtask

    task automatic sendFrame(input logic [15:0] w [10], input bit gap);
        expGap = gap ? 32 : 16;
        lastCyc = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++)
            applyStimulus(w[i], 1'b1, (i == 9) ? 4'd0 : 4'(i + 1), (i == 9), gap);
        tick();
        expGap = 0;
    endtask

    initial begin
        int pulseBase;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        bit_in = 1'b0; bit_valid = 1'b0; rd_addr = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_word_out", 32'(word_out), 32'h0);
        checkOutput("rst_word_valid", 32'(word_valid), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        tick();

        $display("[TB] back-to-back frame");
        pulseBase = pulses;
        sendFrame(frameA, 1'b0);
        checkOutput("f1_pulses", 32'(pulses - pulseBase), 32'd10);
        checkOutput("f1_done", 32'(done), 32'd1);
        checkOutput("f1_busy", 32'(busy), 32'd0);
        checkOutput("f1_overrun", 32'(overrun), 32'd0);
        checkOutput("f1_idx", 32'(word_idx), 32'd0);
        for (int a = 0; a < 16; a++)
            checkMem(4'(a), (a < 10) ? frameA[a] : 16'h0000);

        $display("[TB] gapped frame");
        pulseBase = pulses;
        sendFrame(frameA, 1'b1);
        checkOutput("f2_pulses", 32'(pulses - pulseBase), 32'd10);
        checkOutput("f2_done", 32'(done), 32'd1);
        for (int a = 0; a < 16; a++)
            checkMem(4'(a), (a < 10) ? frameA[a] : 16'h0000);

        $display("[TB] partial word then abort");
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 7; b++) begin
            bit_in = 1'b1; bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_idx", 32'(word_idx), 32'd0);
        pulseBase = pulses;
        sendFrame(frameF, 1'b0);
        checkOutput("f3_pulses", 32'(pulses - pulseBase), 32'd10);
        checkOutput("f3_overrun", 32'(overrun), 32'd0);
        for (int a = 0; a < 10; a++)
            checkMem(4'(a), 16'hFFFF);

        $display("[TB] overrun in DONE");
        bit_in = 1'b0; bit_valid = 1'b1;
        repeat (3) tick();
        bit_valid = 1'b0;
        checkOutput("ovr_set", 32'(overrun), 32'd1);
        checkOutput("ovr_done", 32'(done), 32'd1);
        checkMem(4'd0, 16'hFFFF);
        checkMem(4'd9, 16'hFFFF);
        checkMem(4'd10, 16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("ovr_cleared", 32'(overrun), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        $display("[TB] start and abort together");
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checkOutput("sa_busy", 32'(busy), 32'd0);
        checkOutput("sa_done", 32'(done), 32'd0);

        $display("[TB] start with valid bit");
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        applyStimulus(16'h0002, 1'b1, 4'd1, 1'b0, 1'b0);
        tick();
        checkMem(4'd0, 16'h0002);

        $display("[TB] reset mid-word");
        applyStimulus(16'h00A5, 1'b1, 4'd2, 1'b0, 1'b0);
        applyStimulus(16'h5A00, 1'b1, 4'd3, 1'b0, 1'b0);
        applyStimulus(16'hBEEF, 1'b1, 4'd4, 1'b0, 1'b0);
        applyStimulus(16'h8001, 1'b1, 4'd5, 1'b0, 1'b0);
        for (int b = 0; b < 5; b++) begin
            bit_in = 1'b1; bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        checkMem(4'd4, 16'h8001);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_word_out", 32'(word_out), 32'h0);
        checkOutput("arst_word_idx", 32'(word_idx), 32'h0);
        checkOutput("arst_busy", 32'(busy), 32'h0);
        checkOutput("arst_done", 32'(done), 32'h0);
        checkOutput("arst_overrun", 32'(overrun), 32'h0);
        checkOutput("arst_word_valid", 32'(word_valid), 32'h0);
        for (int a = 0; a < 16; a++)
            checkMem(4'(a), 16'h0000);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
